// File: rtl/mt_pkg.sv
// mt_pkg: shared types, limits and the index-to-one-hot decode for the M/T sequencer
package mt_pkg;

    localparam int unsigned MAX_MT = 8;
    localparam int unsigned IDX_W  = $clog2(MAX_MT);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } seq_state_e;

    // Bits at or above width are masked so an out-of-range index decodes to all zeros
    function automatic logic [MAX_MT-1:0] onehot(input logic [IDX_W-1:0] idx, input int unsigned width);
        logic [MAX_MT-1:0] mask;
        mask = (MAX_MT'(1) << width) - MAX_MT'(1);
        return (MAX_MT'(1) << idx) & mask;
    endfunction

endpackage

// File: rtl/mt_counter.sv
// mt_counter: binary index counter 0..N-1 with clear, hold, increment and wrap flag
//   clr  - next index is 0 (wins over inc)
//   inc  - next index is cnt+1, or 0 with wrap=1 when cnt is N-1
//   cnt  - registered index
//   nxt  - index loaded at the coming edge (0 under reset)
//   wrap - increment this cycle runs past the last index
module mt_counter
    import mt_pkg::*;
#(
    parameter int unsigned N = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] cnt,
    output logic [IDX_W-1:0] nxt,
    output logic             wrap
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap  = inc && !clr && cnt_q == LAST;
        cnt_d = (clr || wrap) ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign nxt = reset ? '0 : cnt_d;

endmodule

// File: rtl/mt_sequencer.sv
// mt_sequencer: parametrised one-hot machine-cycle / T-state sequencer with wait stall and bus hold
//   next_m/set_m1 - end the current M (advance / back to M1) at the end of this T
//   wait_req      - stalls the T counter while in T(WAIT_T)
//   busrq/busack  - hold request taken at an M boundary, acknowledged while frozen
//   m_state/t_state - registered one-hot M and T strobes (bit0 = M1/T1)
//   in_wait       - registered, high in each inserted wait cycle
//   ovf           - sticky: M or T ran past its last index
//   m_boundary    - combinational, current cycle ends an M
module mt_sequencer
    import mt_pkg::*;
#(
    parameter int unsigned NUM_M  = 6,
    parameter int unsigned NUM_T  = 6,
    parameter int unsigned WAIT_T = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             next_m,
    input  logic             set_m1,
    input  logic             wait_req,
    input  logic             busrq,
    output logic [NUM_M-1:0] m_state,
    output logic [NUM_T-1:0] t_state,
    output logic             in_wait,
    output logic             busack,
    output logic             ovf,
    output logic             m_boundary
);

    if (NUM_M < 2 || NUM_M > MAX_MT) begin : g_bad_num_m
        $error("mt_sequencer: NUM_M must be in 2..8");
    end
    if (NUM_T < 3 || NUM_T > MAX_MT) begin : g_bad_num_t
        $error("mt_sequencer: NUM_T must be in 3..8");
    end
    if (WAIT_T < 1 || WAIT_T > NUM_T) begin : g_bad_wait_t
        $error("mt_sequencer: WAIT_T must be in 1..NUM_T");
    end

    localparam logic [IDX_W-1:0] WAIT_IDX = IDX_W'(WAIT_T - 1);

    seq_state_e       state_q, state_d;
    logic [NUM_M-1:0] m_state_q, m_state_d;
    logic [NUM_T-1:0] t_state_q, t_state_d;
    logic             in_wait_q, in_wait_d;
    logic             busack_q, busack_d;
    logic             ovf_q, ovf_d;

    logic             run, stall;
    logic             m_clr, m_inc, t_clr, t_inc;
    logic [IDX_W-1:0] m_cnt, m_nxt, t_cnt, t_nxt;
    logic             m_wrap, t_wrap;
    logic [MAX_MT-1:0] m_oh, t_oh;

    mt_counter #(.N(NUM_M)) u_m_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (m_clr),
        .inc   (m_inc),
        .cnt   (m_cnt),
        .nxt   (m_nxt),
        .wrap  (m_wrap)
    );

    mt_counter #(.N(NUM_T)) u_t_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (t_clr),
        .inc   (t_inc),
        .cnt   (t_cnt),
        .nxt   (t_nxt),
        .wrap  (t_wrap)
    );

    // HOLD freezes both counters; RUN applies stall > set_m1 > next_m > T+1
    always_comb begin
        run        = state_q == RUN;
        stall      = run && t_cnt == WAIT_IDX && wait_req;
        m_boundary = run && !stall && (next_m || set_m1);
        t_clr      = m_boundary;
        t_inc      = run && !stall && !m_boundary;
        m_inc      = m_boundary && !set_m1;
        // Running off the last T without an M end restarts the instruction
        m_clr      = (m_boundary && set_m1) || t_wrap;
        ovf_d      = ovf_q || m_wrap || t_wrap;
        state_d    = run ? ((m_boundary && busrq) ? HOLD : RUN) : (busrq ? HOLD : RUN);
        busack_d   = state_d == HOLD;
        in_wait_d  = stall;
        m_oh       = onehot(m_nxt, NUM_M);
        t_oh       = onehot(t_nxt, NUM_T);
        m_state_d  = m_oh[NUM_M-1:0];
        t_state_d  = t_oh[NUM_T-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            m_state_q <= NUM_M'(1);
            t_state_q <= NUM_T'(1);
            in_wait_q <= 1'b0;
            busack_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_state_q <= m_state_d;
            t_state_q <= t_state_d;
            in_wait_q <= in_wait_d;
            busack_q  <= busack_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ({1'b0, m_cnt} < (IDX_W + 1)'(NUM_M));
            assert ({1'b0, t_cnt} < (IDX_W + 1)'(NUM_T));
        end
    end

    assign m_state = m_state_q;
    assign t_state = t_state_q;
    assign in_wait = in_wait_q;
    assign busack  = busack_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_mt_sequencer.sv
// tb_mt_sequencer: directed test-plan sequences plus random traffic on two parameterisations against an index model
module tb_mt_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst, nm, sm, wr, br;
    logic [5:0] m_a, t_a;
    logic [2:0] m_b;
    logic [3:0] t_b;
    logic       iw_a, ack_a, ovf_a, bnd_a;
    logic       iw_b, ack_b, ovf_b, bnd_b;

    mt_sequencer dut_a (
        .clk(clk), .reset(rst[0]), .next_m(nm[0]), .set_m1(sm[0]), .wait_req(wr[0]), .busrq(br[0]),
        .m_state(m_a), .t_state(t_a), .in_wait(iw_a), .busack(ack_a), .ovf(ovf_a), .m_boundary(bnd_a)
    );

    mt_sequencer #(.NUM_M(3), .NUM_T(4), .WAIT_T(2)) dut_b (
        .clk(clk), .reset(rst[1]), .next_m(nm[1]), .set_m1(sm[1]), .wait_req(wr[1]), .busrq(br[1]),
        .m_state(m_b), .t_state(t_b), .in_wait(iw_b), .busack(ack_b), .ovf(ovf_b), .m_boundary(bnd_b)
    );

    typedef struct {
        int m;
        int t;
        bit hold;
        bit ovf;
        bit iw;
    } mdl_t;

    mdl_t ma, mb;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit stalled(mdl_t s, bit w, int wt);
        return !s.hold && s.t == wt - 1 && w;
    endfunction

    function automatic bit ends_m(mdl_t s, bit n, bit e, bit w, int wt);
        return !s.hold && !stalled(s, w, wt) && (n || e);
    endfunction

    function automatic mdl_t step(mdl_t s, bit r, bit n, bit e, bit w, bit b, int nm_, int nt_, int wt);
        mdl_t o;
        o = s;
        o.iw = 0;
        if (r) begin
            o.m = 0; o.t = 0; o.hold = 0; o.ovf = 0;
        end else if (s.hold) begin
            o.hold = b;
        end else if (stalled(s, w, wt)) begin
            o.iw = 1;
        end else begin
            if (e) begin
                o.m = 0; o.t = 0;
            end else if (n) begin
                o.t = 0;
                if (s.m == nm_ - 1) begin o.m = 0; o.ovf = 1; end
                else o.m = s.m + 1;
            end else if (s.t == nt_ - 1) begin
                o.m = 0; o.t = 0; o.ovf = 1;
            end else begin
                o.t = s.t + 1;
            end
            if ((n || e) && b) o.hold = 1;
        end
        return o;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (!rst[0]) check("bnd_a", 32'(bnd_a), 32'(ends_m(ma, nm[0], sm[0], wr[0], 2)));
        if (!rst[1]) check("bnd_b", 32'(bnd_b), 32'(ends_m(mb, nm[1], sm[1], wr[1], 2)));
        @(posedge clk);
        ma = step(ma, rst[0], nm[0], sm[0], wr[0], br[0], 6, 6, 2);
        mb = step(mb, rst[1], nm[1], sm[1], wr[1], br[1], 3, 4, 2);
        #1;
        check("m_a", 32'(m_a), 32'(1) << ma.m);
        check("t_a", 32'(t_a), 32'(1) << ma.t);
        check("iw_a", 32'(iw_a), 32'(ma.iw));
        check("ack_a", 32'(ack_a), 32'(ma.hold));
        check("ovf_a", 32'(ovf_a), 32'(ma.ovf));
        check("m_b", 32'(m_b), 32'(1) << mb.m);
        check("t_b", 32'(t_b), 32'(1) << mb.t);
        check("iw_b", 32'(iw_b), 32'(mb.iw));
        check("ack_b", 32'(ack_b), 32'(mb.hold));
        check("ovf_b", 32'(ovf_b), 32'(mb.ovf));
    endtask

    task automatic quiet();
        rst = 0; nm = 0; sm = 0; wr = 0; br = 0;
    endtask

    task automatic reset_a();
        quiet();
        rst[0] = 1;
        tick();
        rst[0] = 0;
    endtask

    initial begin
        ma = '{0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0};
        quiet();
        rst = 2'b11;
        tick();
        check("rst_m", 32'(m_a), 32'h1);
        check("rst_t", 32'(t_a), 32'h1);
        check("rst_ovf", 32'(ovf_a), 32'h0);
        rst = 2'b00;

        // idle through all six T-states, then wrap with overflow
        repeat (5) tick();
        check("idle_t6", 32'(t_a), 32'h20);
        check("idle_ovf0", 32'(ovf_a), 32'h0);
        tick();
        check("wrap_t", 32'(t_a), 32'h1);
        check("wrap_m", 32'(m_a), 32'h1);
        check("wrap_ovf", 32'(ovf_a), 32'h1);

        // next_m at T4 of M1, set_m1 at T3 of M3
        reset_a();
        repeat (3) tick();
        nm[0] = 1; tick(); nm[0] = 0;
        check("nm_m2", 32'(m_a), 32'h2);
        check("nm_t1", 32'(t_a), 32'h1);
        nm[0] = 1; tick(); nm[0] = 0;
        repeat (2) tick();
        check("m3_t3", 32'(t_a), 32'h4);
        sm[0] = 1; tick(); sm[0] = 0;
        check("sm_m1", 32'(m_a), 32'h1);
        check("sm_t1", 32'(t_a), 32'h1);
        check("sm_ovf", 32'(ovf_a), 32'h0);

        // three wait cycles in T2
        reset_a();
        tick();
        wr[0] = 1;
        repeat (3) begin
            tick();
            check("wait_t2", 32'(t_a), 32'h2);
            check("wait_iw", 32'(iw_a), 32'h1);
        end
        wr[0] = 0; tick();
        check("wait_t3", 32'(t_a), 32'h4);
        check("wait_iw0", 32'(iw_a), 32'h0);

        // bus hold taken at the end of M2
        reset_a();
        nm[0] = 1; tick(); nm[0] = 0;
        repeat (2) tick();
        nm[0] = 1; br[0] = 1; tick();
        check("hold_m3", 32'(m_a), 32'h4);
        check("hold_ack", 32'(ack_a), 32'h1);
        for (int i = 0; i < 5; i++) begin
            nm[0] = i[0]; tick();
            check("frozen_t", 32'(t_a), 32'h1);
        end
        nm[0] = 0; br[0] = 0; tick();
        check("rel_ack", 32'(ack_a), 32'h0);
        check("rel_t1", 32'(t_a), 32'h1);
        tick();
        check("rel_t2", 32'(t_a), 32'h2);

        // small configuration: M overflow and mid-instruction reset
        quiet(); rst[1] = 1; tick(); rst[1] = 0;
        nm[1] = 1; repeat (2) tick();
        check("b_m3", 32'(m_b), 32'h4);
        tick();
        check("b_m1", 32'(m_b), 32'h1);
        check("b_ovf", 32'(ovf_b), 32'h1);
        tick(); nm[1] = 0;
        repeat (2) tick();
        check("b_t3", 32'(t_b), 32'h4);
        rst[1] = 1; tick(); rst[1] = 0;
        check("b_rst_m", 32'(m_b), 32'h1);
        check("b_rst_ovf", 32'(ovf_b), 32'h0);

        // set_m1 beats next_m; stall masks next_m
        reset_a();
        nm[0] = 1; tick(); nm[0] = 0;
        tick();
        nm[0] = 1; sm[0] = 1; tick(); sm[0] = 0; nm[0] = 0;
        check("both_m1", 32'(m_a), 32'h1);
        tick();
        nm[0] = 1; wr[0] = 1;
        repeat (2) tick();
        check("stall_m1", 32'(m_a), 32'h1);
        wr[0] = 0; tick(); nm[0] = 0;
        check("stall_end_m2", 32'(m_a), 32'h2);

        // random traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                rst[k] = $urandom_range(0, 199) == 0;
                nm[k]  = $urandom_range(0, 5) == 0;
                sm[k]  = $urandom_range(0, 9) == 0;
                wr[k]  = $urandom_range(0, 2) == 0;
                br[k]  = $urandom_range(0, 7) == 0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mt_sequencer.md
Name: mt_sequencer

Overview:
- Parametrised machine-cycle (M) / clock-state (T) sequencer that drives the one-hot M and T strobes consumed by the execute matrix.
- Successor to the fixed 6x6 M/T timing generator:
  - M and T depth are parameters.
  - Adds a wait-state insertion point.
  - Adds bus-request hold at M boundaries.
  - Adds a sticky overflow diagnostic.
- Sits between pla_decode/execute (which supply nextM/setM1) and the bus/timing logic.

Parameters:
NUM_M, 6, number of machine cycles (one-hot width of m_state); legal range 2..8
NUM_T, 6, number of T-states per machine cycle (one-hot width of t_state); legal range 3..8
WAIT_T, 2, T-state index (1-based) at which wait_req is sampled and the T counter may stall

Ports:
clk  input  1  core clock
reset  input  1  synchronous active-high reset
next_m  input  1  end the current M at the end of this T; next cycle is M(n+1), T1
set_m1  input  1  end the instruction at the end of this T; next cycle is M1, T1
wait_req  input  1  external wait request; sampled only while in T(WAIT_T)
busrq  input  1  bus request; honoured only at an M boundary
m_state  output  NUM_M  one-hot current machine cycle (bit0 = M1)
t_state  output  NUM_T  one-hot current T-state (bit0 = T1)
in_wait  output  1  high during each inserted wait cycle
busack  output  1  high while the sequencer is held for a bus request
ovf  output  1  sticky overflow: T or M ran past its last index
m_boundary  output  1  combinational; high when the current cycle ends an M (next_m or set_m1 active, and no stall)

Behaviour:
- Internal state: binary M index (0..NUM_M-1), binary T index (0..NUM_T-1), 2-state FSM {RUN, HOLD}.
  - Outputs are registered one-hot decodes.
- Reset (synchronous, priority over all inputs): M1, T1, RUN, in_wait=0, busack=0, ovf=0.
  - Reset mid-instruction discards all state the next cycle.
- RUN, per clk edge, in priority order:
  1. Stall: T index == WAIT_T-1 and wait_req=1. Hold M/T, assert in_wait, ignore next_m/set_m1; m_boundary=0.
  2. set_m1=1: go to M1, T1.
  3. next_m=1:
     - M < last: go to M+1, T1.
     - M at last: go to M1, T1 and set ovf.
  4. Otherwise T+1.
     - T at last with no next_m/set_m1: wrap to M1, T1 and set ovf.
- Simultaneous next_m and set_m1: set_m1 wins.
- Bus request: if m_boundary=1 and busrq=1, perform the M/T update, then enter HOLD.
  - busack rises the same edge.
  - M/T show the new M, T1, frozen.
- HOLD: M/T frozen; next_m, set_m1 and wait_req ignored.
  - busrq=0 → RUN the next edge, busack falls the same edge.
  - Execution resumes at the frozen M, T1.
- in_wait is registered. It is 1 in every cycle where the stall held the T index, and cleared the edge the stall ends.
- WAIT_T > NUM_T is a parameter error; an elaboration-time assertion is required.
- ovf clears only on reset.
- Latency: input sampled on edge k → new m_state/t_state visible after edge k (one register stage).

Decomposition:
- Shared package mt_pkg holds:
  - typedef seq_state_e {RUN, HOLD};
  - constant MAX_MT = 8;
  - function onehot(idx, width) for the index → one-hot decode.
- One sub-module is natural: mt_counter.
  - Parametrised binary counter with clear, hold, increment and wrap flag.
  - Instantiated twice, for the M and T indices.
- FSM and priority logic stay in mt_sequencer.

Test Plan:
- Default params, reset then idle 7 cycles: t_state 000001,000010,...,100000, then wrap to 000001 with m_state 000001 and ovf=1.
- next_m at T4 of M1: following cycle m_state=000010, t_state=000001. set_m1 at T3 of M3: next cycle M1/T1, ovf stays 0.
- wait_req=1 held for 3 cycles while in T2: t_state stays 000010 for 4 cycles total, in_wait=1 for 3 cycles, then T3.
- busrq=1 with next_m at T3 of M2: next cycle M3/T1, busack=1. Frozen for 5 cycles with next_m toggling. Drop busrq: busack=0, T advances from T1.
- NUM_M=3, NUM_T=4: next_m in M3 → M1/T1 and ovf=1. Assert reset during T3 of M2 → M1/T1 and ovf=0 after one edge.
- next_m and set_m1 together at M2 T2 → M1 T1 (not M3). Stall with next_m=1 at WAIT_T → next_m ignored until wait_req drops.
